anchor_swing_sequencer: RTL and testbench

ANCHOR_SWING_SEQUENCER -- requirements
Module: anchor_swing_sequencer

---
 rtl/anchor_swing_sequencer_pkg.sv | 28 ++
 rtl/anchor_swing_sequencer_if.sv | 25 ++
 rtl/anchor_swing_sequencer_swing_stepper.sv | 60 ++++++
 rtl/anchor_swing_sequencer.sv | 106 ++++++++++
 tb/tb_anchor_swing_sequencer.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/anchor_swing_sequencer_pkg.sv
// Shared definitions for the anchor swing sequencer: FSM encoding, default
// geometry and the bundle of per-state control outputs.
package anchor_swing_sequencer_pkg;

    localparam int POS_MAX_DEFAULT = 10;
    localparam int POS_W_DEFAULT   = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAW       = 3'd1,
        ST_WAIT_DRAW  = 3'd2,
        ST_TIMER      = 3'd3,
        ST_ERASE      = 3'd4,
        ST_WAIT_ERASE = 3'd5,
        ST_STEP       = 3'd6,
        ST_HOLD       = 3'd7
    } state_t;

    typedef struct packed {
        logic draw_start;
        logic draw_erase;
        logic pos_valid;
        logic enable_counter;
        logic frozen;
        logic step;
    } seq_ctrl_t;

endpackage

// File: rtl/anchor_swing_sequencer_if.sv
// Plotter and frame-delay counter handshake seen by the swing sequencer.
interface anchor_swing_sequencer_if
    import anchor_swing_sequencer_pkg::*;
#(
    parameter int POS_W = POS_W_DEFAULT
);

    logic             draw_start;
    logic             draw_erase;
    logic [POS_W-1:0] draw_pos;
    logic             draw_done;
    logic             enable_counter;
    logic             counter_done;

    modport master (
        output draw_start, draw_erase, draw_pos, enable_counter,
        input  draw_done, counter_done
    );

    modport slave (
        input  draw_start, draw_erase, draw_pos, enable_counter,
        output draw_done, counter_done
    );

endinterface

// File: rtl/anchor_swing_sequencer_swing_stepper.sv
// Bounce logic for the swing: moves one position per step pulse and reverses
// direction at either end without ever leaving 0..POS_MAX.
module swing_stepper
    import anchor_swing_sequencer_pkg::*;
#(
    parameter int POS_MAX = POS_MAX_DEFAULT,
    parameter int POS_W   = POS_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             step,
    output logic [POS_W-1:0] pos,
    output logic             dir
);

    localparam logic [POS_W-1:0] TOP = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0] ONE = POS_W'(1);

    logic [POS_W-1:0] pos_nxt;
    logic             dir_nxt;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pos_nxt = pos;
        dir_nxt = dir;
        if (clear) begin
            pos_nxt = '0;
            dir_nxt = 1'b1;
        end else if (step) begin
            if (dir) begin
                if (pos >= TOP) begin
                    dir_nxt = 1'b0;
                    pos_nxt = TOP - ONE;
                end else begin
                    pos_nxt = pos + ONE;
                end
            end else begin
                if (pos == '0) begin
                    dir_nxt = 1'b1;
                    pos_nxt = ONE;
                end else begin
                    pos_nxt = pos - ONE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos <= '0;
            dir <= 1'b1;
        end else begin
            pos <= pos_nxt;
            dir <= dir_nxt;
        end
    end

endmodule

// File: rtl/anchor_swing_sequencer.sv
// Swing sequencer: draws the anchor sprite, waits a frame delay, erases it,
// steps the position and repeats; a fire request freezes the swing in place.
module anchor_swing_sequencer
    import anchor_swing_sequencer_pkg::*;
#(
    parameter int POS_MAX = POS_MAX_DEFAULT,
    parameter int POS_W   = POS_W_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            go,
    input  logic                            fire,
    anchor_swing_sequencer_if.master        bus,
    output logic [POS_W-1:0]                pos,
    output logic                            dir,
    output logic                            frozen
);

    state_t    state;
    state_t    state_nxt;
    seq_ctrl_t ctrl;
    logic      fire_pending;
    logic      timer_armed;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // timer_armed is low in the first TIMER cycle so a stale counter_done is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fire_pending <= 1'b0;
            timer_armed  <= 1'b0;
        end else begin
            timer_armed <= (state == ST_TIMER) && (state_nxt == ST_TIMER);
            if (state_nxt == ST_IDLE) begin
                fire_pending <= 1'b0;
            end else if (fire && (state != ST_IDLE)) begin
                fire_pending <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (go) state_nxt = ST_DRAW;
            ST_DRAW:       state_nxt = ST_WAIT_DRAW;
            ST_WAIT_DRAW:  if (bus.draw_done) state_nxt = go ? ST_TIMER : ST_IDLE;
            ST_TIMER: begin
                if (!go) begin
                    state_nxt = ST_IDLE;
                end else if (timer_armed && bus.counter_done) begin
                    state_nxt = (fire_pending || fire) ? ST_HOLD : ST_ERASE;
                end
            end
            ST_ERASE:      state_nxt = ST_WAIT_ERASE;
            ST_WAIT_ERASE: if (bus.draw_done) state_nxt = ST_STEP;
            ST_STEP:       state_nxt = ST_DRAW;
            ST_HOLD:       if (!go) state_nxt = ST_IDLE;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            ST_DRAW:       begin ctrl.draw_start = 1'b1; ctrl.pos_valid = 1'b1; end
            ST_WAIT_DRAW:  ctrl.pos_valid = 1'b1;
            ST_TIMER:      ctrl.enable_counter = 1'b1;
            ST_ERASE:      begin
                ctrl.draw_start = 1'b1;
                ctrl.draw_erase = 1'b1;
                ctrl.pos_valid  = 1'b1;
            end
            ST_WAIT_ERASE: begin ctrl.draw_erase = 1'b1; ctrl.pos_valid = 1'b1; end
            ST_STEP:       ctrl.step = 1'b1;
            ST_HOLD:       ctrl.frozen = 1'b1;
            default:       ctrl = '0;
        endcase
    end

    assign bus.draw_start     = ctrl.draw_start;
    assign bus.draw_erase     = ctrl.draw_erase;
    assign bus.draw_pos       = ctrl.pos_valid ? pos : '0;
    assign bus.enable_counter = ctrl.enable_counter;
    assign frozen             = ctrl.frozen;

    // Clearing on the way into IDLE means pos already reads 0 in the first IDLE cycle.
    swing_stepper #(
        .POS_MAX (POS_MAX),
        .POS_W   (POS_W)
    ) u_stepper (
        .clk   (clk),
        .reset (reset),
        .clear (state_nxt == ST_IDLE),
        .step  (ctrl.step),
        .pos   (pos),
        .dir   (dir)
    );

endmodule

// File: tb/tb_anchor_swing_sequencer.sv
// Directed bench for anchor_swing_sequencer: a cycle-by-cycle vector table plus
// modelled plotter/counter runs for the bounce, freeze and reset corner cases.
module tb_anchor_swing_sequencer;

    logic       clk;
    logic       reset;
    logic       go;
    logic       fire;
    logic [3:0] pos;
    logic       dir;
    logic       frozen;

    int checks = 0;
    int errors = 0;

    anchor_swing_sequencer_if #(.POS_W(4)) bus ();

    anchor_swing_sequencer #(.POS_MAX(10), .POS_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .go     (go),
        .fire   (fire),
        .bus    (bus),
        .pos    (pos),
        .dir    (dir),
        .frozen (frozen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       go, fire, cd, dd;
        logic       ds, er;
        logic [3:0] dp;
        logic       en;
        logic [3:0] p;
        logic       d, fr;
    } vec_t;

    vec_t vq[$];

    int plot_cnt;
    int en_cnt;
    int ds_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic g, f, c, d_in, s, e, input logic [3:0] dpos,
                           input logic n, input logic [3:0] p, input logic d, r);
        vq.push_back({g, f, c, d_in, s, e, dpos, n, p, d, r});
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        go = 1'b0;
        fire = 1'b0;
        bus.draw_done = 1'b0;
        bus.counter_done = 1'b0;
        plot_cnt = 0;
        en_cnt = 0;
        ds_count = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Plotter answers 3 cycles after draw_start; counter finishes 10 cycles into enable.
    // fire_mode: 0 none, 1 pulse this cycle, 2 pulse together with counter_done.
    task automatic env_cycle(input int fire_mode);
        logic cd;
        logic prev_en;
        cd = bus.enable_counter && (en_cnt >= 10);
        bus.counter_done = cd;
        bus.draw_done = (plot_cnt == 1);
        fire = (fire_mode == 1) || ((fire_mode == 2) && cd);
        prev_en = bus.enable_counter;
        tick();
        fire = 1'b0;
        if (prev_en && cd) check("enable_drop_after_done", bus.enable_counter, 0);
        if (bus.draw_start) begin
            plot_cnt = 4;
            ds_count++;
        end else if (plot_cnt > 0) begin
            plot_cnt--;
        end
        if (bus.enable_counter) en_cnt++;
        else en_cnt = 0;
    endtask

    task automatic run_until_draw(input logic [3:0] p);
        int  cyc;
        bit  ok;
        ok = 1'b0;
        cyc = 0;
        while (!ok && cyc < 1000) begin
            env_cycle(0);
            cyc++;
            if (bus.draw_start && !bus.draw_erase && bus.draw_pos == p) ok = 1'b1;
        end
        check($sformatf("reach_draw_pos%0d", p), ok, 1);
    endtask

    initial begin
        int          nops;
        int          op;
        int          cyc;
        int          base;
        logic [3:0]  ep[$];
        logic        ee[$];
        logic        ed[$];

        // go fire cd dd | ds er dp en pos dir frozen
        add_vec(0,0,0,0, 0,0,4'd0,0,4'd0,1,0);  // idle
        add_vec(1,0,0,0, 1,0,4'd0,0,4'd0,1,0);  // draw 0, one-cycle latency
        add_vec(1,0,0,0, 0,0,4'd0,0,4'd0,1,0);  // wait_draw
        add_vec(1,0,0,0, 0,0,4'd0,0,4'd0,1,0);
        add_vec(1,0,1,1, 0,0,4'd0,1,4'd0,1,0);  // timer, counter_done already high
        add_vec(1,0,1,0, 0,0,4'd0,1,4'd0,1,0);  // first timer cycle ignores it
        add_vec(1,0,1,0, 1,1,4'd0,0,4'd0,1,0);  // erase 0
        add_vec(1,0,0,0, 0,1,4'd0,0,4'd0,1,0);  // wait_erase
        add_vec(1,0,0,1, 0,0,4'd0,0,4'd0,1,0);  // step
        add_vec(1,0,0,0, 1,0,4'd1,0,4'd1,1,0);  // draw 1
        add_vec(1,0,0,1, 0,0,4'd1,0,4'd1,1,0);  // stray draw_done in DRAW ignored
        add_vec(1,0,0,1, 0,0,4'd0,1,4'd1,1,0);  // timer
        add_vec(1,1,0,0, 0,0,4'd0,1,4'd1,1,0);  // fire pending
        add_vec(1,0,1,0, 0,0,4'd0,0,4'd1,1,1);  // hold
        add_vec(1,0,0,0, 0,0,4'd0,0,4'd1,1,1);
        add_vec(0,0,0,0, 0,0,4'd0,0,4'd0,1,0);  // back to idle, pos cleared
        add_vec(0,1,0,0, 0,0,4'd0,0,4'd0,1,0);  // fire in idle ignored
        add_vec(1,0,0,0, 1,0,4'd0,0,4'd0,1,0);
        add_vec(1,0,0,0, 0,0,4'd0,0,4'd0,1,0);
        add_vec(1,0,0,1, 0,0,4'd0,1,4'd0,1,0);
        add_vec(0,0,0,0, 0,0,4'd0,0,4'd0,1,0);  // go low in timer
        add_vec(1,0,0,0, 1,0,4'd0,0,4'd0,1,0);
        add_vec(1,0,0,0, 0,0,4'd0,0,4'd0,1,0);
        add_vec(1,0,0,1, 0,0,4'd0,1,4'd0,1,0);
        add_vec(1,0,0,0, 0,0,4'd0,1,4'd0,1,0);
        add_vec(1,0,1,0, 1,1,4'd0,0,4'd0,1,0);  // erase, not hold: fire cleared in idle
        add_vec(1,0,0,0, 0,1,4'd0,0,4'd0,1,0);
        add_vec(0,0,0,1, 0,0,4'd0,0,4'd0,1,0);  // go dropped in wait_erase
        add_vec(0,0,0,0, 1,0,4'd1,0,4'd1,1,0);  // handshake still completes
        add_vec(0,0,0,0, 0,0,4'd1,0,4'd1,1,0);
        add_vec(0,0,0,1, 0,0,4'd0,0,4'd0,1,0);  // then idle
        add_vec(0,0,0,0, 0,0,4'd0,0,4'd0,1,0);

        reset = 1'b1;
        go = 1'b0;
        fire = 1'b0;
        bus.draw_done = 1'b0;
        bus.counter_done = 1'b0;
        #12;
        check("rst_draw_start", bus.draw_start, 0);
        check("rst_enable", bus.enable_counter, 0);
        check("rst_pos", pos, 0);
        check("rst_dir", dir, 1);
        check("rst_frozen", frozen, 0);
        tick();
        reset = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            go = vq[i].go;
            fire = vq[i].fire;
            bus.counter_done = vq[i].cd;
            bus.draw_done = vq[i].dd;
            tick();
            check($sformatf("v%0d.draw_start", i), bus.draw_start, vq[i].ds);
            check($sformatf("v%0d.draw_erase", i), bus.draw_erase, vq[i].er);
            check($sformatf("v%0d.draw_pos", i), bus.draw_pos, vq[i].dp);
            check($sformatf("v%0d.enable", i), bus.enable_counter, vq[i].en);
            check($sformatf("v%0d.pos", i), pos, vq[i].p);
            check($sformatf("v%0d.dir", i), dir, vq[i].d);
            check($sformatf("v%0d.frozen", i), frozen, vq[i].fr);
        end

        // Full bounce: 0..10 up, 10..0 down, then back to 1.
        for (int p = 0; p <= 10; p++) begin
            ep.push_back(4'(p)); ee.push_back(1'b0); ed.push_back(1'b1);
            ep.push_back(4'(p)); ee.push_back(1'b1); ed.push_back(1'b1);
        end
        for (int p = 9; p >= 0; p--) begin
            ep.push_back(4'(p)); ee.push_back(1'b0); ed.push_back(1'b0);
            ep.push_back(4'(p)); ee.push_back(1'b1); ed.push_back(1'b0);
        end
        ep.push_back(4'd1); ee.push_back(1'b0); ed.push_back(1'b1);
        nops = ep.size();

        reset_dut();
        go = 1'b1;
        op = 0;
        cyc = 0;
        while (op < nops && cyc < 2000) begin
            env_cycle(0);
            cyc++;
            if (bus.draw_start) begin
                check($sformatf("bounce%0d.erase", op), bus.draw_erase, ee[op]);
                check($sformatf("bounce%0d.pos", op), bus.draw_pos, ep[op]);
                check($sformatf("bounce%0d.dir", op), dir, ed[op]);
                op++;
            end
        end
        check("bounce_ops_done", op, nops);

        // Fire while waiting on the draw at position 4 freezes there.
        reset_dut();
        go = 1'b1;
        run_until_draw(4'd4);
        env_cycle(0);
        env_cycle(1);
        base = ds_count;
        for (int i = 0; i < 40; i++) env_cycle(0);
        check("fire_frozen", frozen, 1);
        check("fire_pos", pos, 4);
        check("fire_enable_low", bus.enable_counter, 0);
        check("fire_no_draws", ds_count - base, 0);
        go = 1'b0;
        env_cycle(0);
        check("fire_idle_frozen", frozen, 0);
        check("fire_idle_pos", pos, 0);

        // Fire coincident with counter_done also holds.
        reset_dut();
        go = 1'b1;
        run_until_draw(4'd2);
        base = ds_count;
        for (int i = 0; i < 40; i++) env_cycle(2);
        check("coincident_frozen", frozen, 1);
        check("coincident_pos", pos, 2);
        check("coincident_no_draws", ds_count - base, 0);

        // Asynchronous reset in WAIT_DRAW.
        reset_dut();
        go = 1'b1;
        run_until_draw(4'd1);
        env_cycle(0);
        check("pre_reset_draw_pos", bus.draw_pos, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_draw_pos", bus.draw_pos, 0);
        check("async_pos", pos, 0);
        check("async_dir", dir, 1);
        check("async_draw_start", bus.draw_start, 0);
        bus.draw_done = 1'b1;
        tick();
        reset = 1'b0;
        go = 1'b0;
        tick();
        check("stray_done_no_start", bus.draw_start, 0);
        check("stray_done_enable", bus.enable_counter, 0);
        bus.draw_done = 1'b0;
        go = 1'b1;
        tick();
        check("restart_draw_start", bus.draw_start, 1);
        check("restart_draw_pos", bus.draw_pos, 0);
        check("restart_erase", bus.draw_erase, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
